// File: rtl/gol_pattern_loader.sv
// Byte-stream loader for the Game-of-Life grid: assembles NBYTES into cells_img, then pulses overwrite.
// Optional macro LOADER_CHECKSUM_EN: expects a trailing XOR checksum byte and raises err on mismatch.
module gol_pattern_loader #(
    parameter int unsigned CELLS_X    = 32,
    parameter int unsigned CELLS_Y    = 18,
    parameter int unsigned OVR_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [CELLS_X*CELLS_Y-1:0] cells_img,
    output logic                       overwrite,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int unsigned NCELLS = CELLS_X * CELLS_Y;
    localparam int unsigned NBYTES = NCELLS / 8;
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1);
    localparam int unsigned IDX_W  = $clog2(NCELLS);
    localparam int unsigned OVR_W  = (OVR_CYCLES > 1) ? $clog2(OVR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);
    localparam logic [OVR_W-1:0] OVR_LAST = OVR_W'(OVR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_STROBE,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [OVR_W-1:0]   r_ovr_cnt;
    logic [NCELLS-1:0]  r_cells;
    logic               r_in_ready;
    logic               r_overwrite;
    logic               r_busy;
    logic               r_done;
    logic [IDX_W-1:0]   w_base;

    // Bit offset of the byte slot addressed by the counter
    assign w_base = IDX_W'(r_cnt) << 3;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_xor;
    logic       r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ovr_cnt   <= '0;
            r_cells     <= '0;
            r_in_ready  <= 1'b0;
            r_overwrite <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_xor       <= 8'h00;
            r_err       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        r_xor      <= 8'h00;
`endif
                    end
                end
                S_LOAD: begin
                    // start restarts the load and drops the byte presented this cycle
                    if (start) begin
                        r_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                        r_xor <= 8'h00;
`endif
                    end else if (in_valid) begin
                        r_cells[w_base +: 8] <= in_data;
`ifdef LOADER_CHECKSUM_EN
                        r_xor <= r_xor ^ in_data;
`endif
                        if (r_cnt == CNT_LAST) begin
`ifdef LOADER_CHECKSUM_EN
                            r_state     <= S_CHECK;
`else
                            r_state     <= S_STROBE;
                            r_in_ready  <= 1'b0;
                            r_overwrite <= 1'b1;
                            r_ovr_cnt   <= '0;
`endif
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
                        r_xor   <= 8'h00;
                    end else if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (in_data == r_xor) begin
                            r_state     <= S_STROBE;
                            r_overwrite <= 1'b1;
                            r_ovr_cnt   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                S_STROBE: begin
                    // Strobe length is fixed; start is ignored here
                    if (r_ovr_cnt == OVR_LAST) begin
                        r_state     <= S_DONE;
                        r_overwrite <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_ovr_cnt <= r_ovr_cnt + OVR_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_overwrite <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign cells_img = r_cells;
    assign overwrite = r_overwrite;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_gol_pattern_loader.sv
// Directed bench for gol_pattern_loader: reset, glider load, back-pressure, restart, ignored starts
// and (with LOADER_CHECKSUM_EN) the checksum path.
module tb_gol_pattern_loader;

    localparam int NB = 72;
    localparam int NC = 576;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [NC-1:0] cells_img;
    logic          overwrite;
    logic          busy;
    logic          done;
    logic          err;

    int errors = 0;
    int checks = 0;

    logic [7:0]    stim [0:NB-1];
    logic [NC-1:0] exp_img;

    int            acc_cnt, ov_cycles, ov_strobes, done_cnt, err_cnt, img_changes;
    logic          ov_q = 1'b0;
    logic [NC-1:0] img_q = '0;

    gol_pattern_loader #(.CELLS_X(32), .CELLS_Y(18), .OVR_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .cells_img(cells_img), .overwrite(overwrite),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Observes pre-edge values of handshake and strobe at every clock
    always @(posedge clk) begin
        if (in_valid && in_ready && !start) acc_cnt++;
        if (overwrite) ov_cycles++;
        if (overwrite && !ov_q) ov_strobes++;
        if (overwrite && ov_q && (cells_img !== img_q)) img_changes++;
        if (done) done_cnt++;
        if (err) err_cnt++;
        ov_q  = overwrite;
        img_q = cells_img;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        acc_cnt = 0; ov_cycles = 0; ov_strobes = 0; done_cnt = 0; err_cnt = 0; img_changes = 0;
    endtask

    task automatic pulse_start(input logic with_valid, input logic [7:0] d);
        start = 1'b1; in_valid = with_valid; in_data = d;
        tick();
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic send_bytes(output int miss);
        miss = 0;
        for (int k = 0; k < NB; k++) begin
            in_data = stim[k]; in_valid = 1'b1;
            if (in_ready !== 1'b1) miss++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_checksum();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < NB; k++) x = x ^ stim[k];
        in_data = x; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`endif
    endtask

    task automatic build_exp();
        exp_img = '0;
        for (int k = 0; k < NB; k++) exp_img[8*k +: 8] = stim[k];
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int miss;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
        checks++; if (overwrite !== 1'b0) begin errors++; $display("FAIL reset_overwrite: got %b exp 0", overwrite); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b%b exp 00", done, err); end
        checks++; if (cells_img !== '0) begin errors++; $display("FAIL reset_cells: got nonzero image exp 0"); end
        rst = 1'b0;
        tick();
        for (int k = 0; k < NB; k++) stim[k] = 8'hC3;
        pulse_start(1'b0, 8'h00);
        send_bytes(miss);
        send_checksum();
        checks++; if (overwrite !== 1'b1) begin errors++; $display("FAIL reset_pre_strobe: got %b exp 1", overwrite); end
        // Async reset in the middle of the strobe, no clock edge in between
        rst = 1'b1;
        #1;
        checks++; if (overwrite !== 1'b0) begin errors++; $display("FAIL reset_mid_strobe_ovr: got %b exp 0", overwrite); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_strobe_busy: got %b exp 0", busy); end
        checks++; if (cells_img !== '0) begin errors++; $display("FAIL reset_mid_strobe_cells: got nonzero image exp 0"); end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_glider();
        int miss;
        clear_mon();
        for (int k = 0; k < NB; k++) stim[k] = 8'h00;
        stim[0] = 8'h02; stim[4] = 8'h04; stim[8] = 8'h07;
        pulse_start(1'b0, 8'h00);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL glider_load_entry: got busy=%b rdy=%b exp 1 1", busy, in_ready); end
        send_bytes(miss);
        send_checksum();
        checks++; if (miss !== 0) begin errors++; $display("FAIL glider_ready_gaps: got %0d exp 0", miss); end
        checks++; if (overwrite !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL glider_lat1: got ovr=%b done=%b exp 1 0", overwrite, done); end
        tick();
        checks++; if (overwrite !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL glider_lat2: got ovr=%b done=%b exp 1 0", overwrite, done); end
        tick();
        checks++; if (overwrite !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL glider_lat3: got ovr=%b done=%b exp 0 1", overwrite, done); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL glider_idle: got done=%b busy=%b exp 0 0", done, busy); end
        exp_img = '0;
        exp_img[1] = 1'b1; exp_img[34] = 1'b1; exp_img[64] = 1'b1; exp_img[65] = 1'b1; exp_img[66] = 1'b1;
        checks++; if (cells_img !== exp_img) begin errors++; $display("FAIL glider_image: got %h exp %h", cells_img[95:0], exp_img[95:0]); end
        checks++; if (ov_cycles !== 2 || ov_strobes !== 1) begin errors++; $display("FAIL glider_strobe: got cycles=%0d strobes=%0d exp 2 1", ov_cycles, ov_strobes); end
        checks++; if (err_cnt !== 0 || img_changes !== 0) begin errors++; $display("FAIL glider_err_stable: got err=%0d chg=%0d exp 0 0", err_cnt, img_changes); end
    endtask

    task automatic test_backpressure();
        int n, guard;
        logic v, rdy;
        clear_mon();
        for (int k = 0; k < NB; k++) stim[k] = 8'($urandom);
        build_exp();
        pulse_start(1'b0, 8'h00);
        n = 0; guard = 0;
        while (n < NB && guard < 2000) begin
            v = 1'($urandom_range(0, 1));
            in_valid = v; in_data = stim[n]; rdy = in_ready;
            tick();
            if (v && rdy) n++;
            guard++;
        end
        in_valid = 1'b0;
        send_checksum();
        checks++; if (n !== NB) begin errors++; $display("FAIL bp_accepts: got %0d exp %0d", n, NB); end
        wait_done(20);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b exp 1", done); end
        checks++; if (cells_img !== exp_img) begin errors++; $display("FAIL bp_image: got %h exp %h", cells_img[127:0], exp_img[127:0]); end
        tick();
    endtask

    task automatic test_restart();
        int miss;
        clear_mon();
        pulse_start(1'b0, 8'h00);
        for (int k = 0; k < 30; k++) begin
            in_data = 8'h3C; in_valid = 1'b1;
            tick();
        end
        pulse_start(1'b1, 8'hAA);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b1 || overwrite !== 1'b0) begin errors++; $display("FAIL restart_state: got busy=%b rdy=%b ovr=%b exp 1 1 0", busy, in_ready, overwrite); end
        for (int k = 0; k < NB; k++) stim[k] = 8'hFF;
        send_bytes(miss);
        send_checksum();
        wait_done(20);
        tick();
        checks++; if (cells_img !== {NC{1'b1}}) begin errors++; $display("FAIL restart_image: got %h exp all ones", cells_img[127:0]); end
        checks++; if (ov_strobes !== 1 || done_cnt !== 1) begin errors++; $display("FAIL restart_strobes: got strobes=%0d done=%0d exp 1 1", ov_strobes, done_cnt); end
    endtask

    task automatic test_start_ignored();
        int miss;
        clear_mon();
        for (int k = 0; k < NB; k++) stim[k] = 8'(k * 3 + 1);
        build_exp();
        pulse_start(1'b0, 8'h00);
        send_bytes(miss);
        send_checksum();
        pulse_start(1'b1, 8'h55);
        wait_done(20);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL strobe_start_done: got %b exp 1", done); end
        tick();
        checks++; if (ov_cycles !== 2 || ov_strobes !== 1) begin errors++; $display("FAIL strobe_start_len: got cycles=%0d strobes=%0d exp 2 1", ov_cycles, ov_strobes); end
        checks++; if (cells_img !== exp_img || busy !== 1'b0) begin errors++; $display("FAIL strobe_start_image: got busy=%b img=%h exp busy=0 img=%h", busy, cells_img[63:0], exp_img[63:0]); end
        // start and in_valid together in IDLE: start wins, byte is not taken
        clear_mon();
        pulse_start(1'b1, 8'hEE);
        checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL idle_start_load: got rdy=%b busy=%b exp 1 1", in_ready, busy); end
        for (int k = 0; k < NB; k++) stim[k] = 8'(255 - k);
        build_exp();
        send_bytes(miss);
        send_checksum();
        wait_done(20);
        tick();
        checks++; if (cells_img !== exp_img) begin errors++; $display("FAIL idle_start_image: got %h exp %h", cells_img[63:0], exp_img[63:0]); end
        checks++; if (ov_cycles !== 2 || done_cnt !== 1) begin errors++; $display("FAIL idle_start_strobe: got cycles=%0d done=%0d exp 2 1", ov_cycles, done_cnt); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int miss;
        clear_mon();
        for (int k = 0; k < NB; k++) stim[k] = 8'hA5;
        pulse_start(1'b0, 8'h00);
        send_bytes(miss);
        checks++; if (in_ready !== 1'b1 || overwrite !== 1'b0) begin errors++; $display("FAIL cks_wait: got rdy=%b ovr=%b exp 1 0", in_ready, overwrite); end
        in_data = 8'h00; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (overwrite !== 1'b1) begin errors++; $display("FAIL cks_good_ovr: got %b exp 1", overwrite); end
        wait_done(20);
        tick();
        checks++; if (done_cnt !== 1 || ov_cycles !== 2 || err_cnt !== 0) begin errors++; $display("FAIL cks_good: got done=%0d cyc=%0d err=%0d exp 1 2 0", done_cnt, ov_cycles, err_cnt); end
        clear_mon();
        pulse_start(1'b0, 8'h00);
        send_bytes(miss);
        in_data = 8'h01; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (err !== 1'b1 || overwrite !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL cks_bad: got err=%b ovr=%b busy=%b exp 1 0 0", err, overwrite, busy); end
        repeat (5) tick();
        checks++; if (err_cnt !== 1 || ov_cycles !== 0 || done_cnt !== 0) begin errors++; $display("FAIL cks_bad_after: got err=%0d cyc=%0d done=%0d exp 1 0 0", err_cnt, ov_cycles, done_cnt); end
    endtask
`endif

    initial begin
        clear_mon();
        test_reset();
        test_glider();
        test_backpressure();
        test_restart();
        test_start_ignored();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
